// File: rtl/dcache.sv
// Direct-mapped, write-through / no-write-allocate data cache with 16-byte lines.
// Loads hit in one cycle; misses refill a full line as four word beats from memory.
module dcache #(
    parameter int NLINES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsq_dc_req,
    input  logic [3:0]  lsq_dc_op,
    input  logic [31:0] lsq_dc_addr,
    input  logic [3:0]  lsq_dc_lsqid,
    input  logic [31:0] lsq_dc_wdata,
    input  logic        lsq_dc_flush,
    output logic        dcache_ready,
    output logic        dcache_valid,
    output logic        dcache_error,
    output logic [3:0]  dcache_lsqid,
    output logic [31:0] dcache_rdata,
    output logic        dc_mem_req,
    output logic        dc_mem_we,
    output logic [31:0] dc_mem_addr,
    output logic [31:0] dc_mem_wdata,
    output logic [3:0]  dc_mem_wmask,
    input  logic        mem_dc_ready,
    input  logic        mem_dc_valid,
    input  logic [31:0] mem_dc_rdata
);
    localparam int IDXW = $clog2(NLINES);
    localparam int TAGW = 28 - IDXW;

    typedef enum logic [1:0] {IDLE, RD_REQ, REFILL, WR_REQ} state_t;
    state_t state;

    logic [31:0]       data_mem [NLINES][4];
    logic [TAGW-1:0]   tag_mem  [NLINES];
    logic [NLINES-1:0] line_valid;

    logic [1:0]  beat;
    logic        kill;
    logic [31:0] req_addr;
    logic [3:0]  req_op;
    logic [3:0]  req_lsqid;

    logic            accept, is_store, misaligned, hit;
    logic [IDXW-1:0] idx, req_idx;
    logic [TAGW-1:0] tag;
    logic [3:0]      st_mask;
    logic [31:0]     st_data, hit_word, refill_word;

    // op[2:1] is the access size, op[3] selects zero extension.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [3:0] op,
                                            input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op[2:1])
            2'b00:   extract = op[3] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   extract = op[3] ? {16'b0, h} : {{16{h[15]}}, h};
            default: extract = word;
        endcase
    endfunction

    assign dcache_ready = (state == IDLE) && !rst;
    assign accept       = lsq_dc_req && dcache_ready && !lsq_dc_flush;
    assign is_store     = lsq_dc_op[0];
    assign idx          = lsq_dc_addr[4 +: IDXW];
    assign tag          = lsq_dc_addr[31 -: TAGW];
    assign hit          = line_valid[idx] && (tag_mem[idx] == tag);
    assign hit_word     = data_mem[idx][lsq_dc_addr[3:2]];
    assign req_idx      = req_addr[4 +: IDXW];
    // The requested word may be arriving on the final beat, not yet in the array.
    assign refill_word  = (beat == req_addr[3:2]) ? mem_dc_rdata
                                                  : data_mem[req_idx][req_addr[3:2]];

    always_comb begin
        misaligned = 1'b0;
        st_mask    = 4'hF;
        st_data    = lsq_dc_wdata;
        case (lsq_dc_op[2:1])
            2'b00: begin
                st_mask = 4'b0001 << lsq_dc_addr[1:0];
                st_data = {4{lsq_dc_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = lsq_dc_addr[0];
                st_mask    = 4'b0011 << lsq_dc_addr[1:0];
                st_data    = {2{lsq_dc_wdata[15:0]}};
            end
            default: misaligned = (lsq_dc_addr[1:0] != 2'b00);
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && mem_dc_valid) begin
            data_mem[req_idx][beat] <= mem_dc_rdata;
        end else if (accept && is_store && !misaligned && hit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (st_mask[i])
                    data_mem[idx][lsq_dc_addr[3:2]][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= '0;
            kill         <= 1'b0;
            line_valid   <= '0;
            req_addr     <= '0;
            req_op       <= '0;
            req_lsqid    <= '0;
            dcache_valid <= 1'b0;
            dcache_error <= 1'b0;
            dcache_lsqid <= '0;
            dcache_rdata <= '0;
            dc_mem_req   <= 1'b0;
            dc_mem_we    <= 1'b0;
            dc_mem_addr  <= '0;
            dc_mem_wdata <= '0;
            dc_mem_wmask <= '0;
        end else begin
            dcache_valid <= 1'b0;
            dcache_error <= 1'b0;
            case (state)
                IDLE: begin
                    kill <= 1'b0;
                    if (accept) begin
                        req_addr  <= lsq_dc_addr;
                        req_op    <= lsq_dc_op;
                        req_lsqid <= lsq_dc_lsqid;
                        if (is_store) begin
                            if (!misaligned) begin
                                state        <= WR_REQ;
                                dc_mem_req   <= 1'b1;
                                dc_mem_we    <= 1'b1;
                                dc_mem_addr  <= {lsq_dc_addr[31:2], 2'b00};
                                dc_mem_wdata <= st_data;
                                dc_mem_wmask <= st_mask;
                            end
                        end else if (misaligned) begin
                            dcache_valid <= 1'b1;
                            dcache_error <= 1'b1;
                            dcache_lsqid <= lsq_dc_lsqid;
                            dcache_rdata <= '0;
                        end else if (hit) begin
                            dcache_valid <= 1'b1;
                            dcache_lsqid <= lsq_dc_lsqid;
                            dcache_rdata <= extract(hit_word, lsq_dc_op, lsq_dc_addr[1:0]);
                        end else begin
                            state        <= RD_REQ;
                            dc_mem_req   <= 1'b1;
                            dc_mem_we    <= 1'b0;
                            dc_mem_addr  <= {lsq_dc_addr[31:4], 4'b0000};
                            dc_mem_wmask <= '0;
                        end
                    end
                end
                RD_REQ: begin
                    if (lsq_dc_flush)
                        kill <= 1'b1;
                    if (mem_dc_ready) begin
                        dc_mem_req <= 1'b0;
                        beat       <= '0;
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (lsq_dc_flush)
                        kill <= 1'b1;
                    if (mem_dc_valid) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            line_valid[req_idx] <= 1'b1;
                            tag_mem[req_idx]    <= req_addr[31 -: TAGW];
                            state               <= IDLE;
                            if (!kill && !lsq_dc_flush) begin
                                dcache_valid <= 1'b1;
                                dcache_lsqid <= req_lsqid;
                                dcache_rdata <= extract(refill_word, req_op, req_addr[1:0]);
                            end
                        end
                    end
                end
                WR_REQ: begin
                    if (mem_dc_ready) begin
                        dc_mem_req <= 1'b0;
                        dc_mem_we  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache: refill, hits, extension, stores, errors, flush, reset.
module tb_dcache;
    logic        clk = 1'b0;
    logic        rst;
    logic        lsq_dc_req, lsq_dc_flush;
    logic [3:0]  lsq_dc_op, lsq_dc_lsqid;
    logic [31:0] lsq_dc_addr, lsq_dc_wdata;
    logic        dcache_ready, dcache_valid, dcache_error;
    logic [3:0]  dcache_lsqid;
    logic [31:0] dcache_rdata;
    logic        dc_mem_req, dc_mem_we;
    logic [31:0] dc_mem_addr, dc_mem_wdata;
    logic [3:0]  dc_mem_wmask;
    logic        mem_dc_ready, mem_dc_valid;
    logic [31:0] mem_dc_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] LB = 4'b0000, LH = 4'b0010, LW = 4'b0100, LBU = 4'b1000, LHU = 4'b1010;
    localparam logic [3:0] SB = 4'b0001, SH = 4'b0011, SW = 4'b0101;

    dcache #(.NLINES(32)) dut (
        .clk(clk), .rst(rst),
        .lsq_dc_req(lsq_dc_req), .lsq_dc_op(lsq_dc_op), .lsq_dc_addr(lsq_dc_addr),
        .lsq_dc_lsqid(lsq_dc_lsqid), .lsq_dc_wdata(lsq_dc_wdata), .lsq_dc_flush(lsq_dc_flush),
        .dcache_ready(dcache_ready), .dcache_valid(dcache_valid), .dcache_error(dcache_error),
        .dcache_lsqid(dcache_lsqid), .dcache_rdata(dcache_rdata),
        .dc_mem_req(dc_mem_req), .dc_mem_we(dc_mem_we), .dc_mem_addr(dc_mem_addr),
        .dc_mem_wdata(dc_mem_wdata), .dc_mem_wmask(dc_mem_wmask),
        .mem_dc_ready(mem_dc_ready), .mem_dc_valid(mem_dc_valid), .mem_dc_rdata(mem_dc_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle request; returns at the negedge after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [3:0] id,
                         input logic [31:0] wd, input logic fl);
        @(negedge clk);
        lsq_dc_req = 1'b1; lsq_dc_op = op; lsq_dc_addr = addr;
        lsq_dc_lsqid = id; lsq_dc_wdata = wd; lsq_dc_flush = fl;
        if (!fl) check("ready_at_issue", dcache_ready, 1'b1);
        @(negedge clk);
        lsq_dc_req = 1'b0; lsq_dc_flush = 1'b0;
    endtask

    task automatic wait_mem(input string tag);
        int n = 0;
        while (dc_mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_mem_req"}, dc_mem_req, 1'b1);
    endtask

    task automatic serve_refill(input string tag, input logic [31:0] addr,
                                input logic [31:0] b0, input logic [31:0] b1,
                                input logic [31:0] b2, input logic [31:0] b3, input int flush_beat);
        logic [31:0] beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        wait_mem(tag);
        check({tag, "_rd_addr"}, dc_mem_addr, addr);
        check({tag, "_rd_we"}, dc_mem_we, 1'b0);
        mem_dc_valid = 1'b1; mem_dc_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_dc_valid = 1'b0;
        check({tag, "_req_held"}, dc_mem_req, 1'b1);
        check({tag, "_busy"}, dcache_ready, 1'b0);
        mem_dc_ready = 1'b1;
        @(negedge clk);
        mem_dc_ready = 1'b0;
        check({tag, "_req_drop"}, dc_mem_req, 1'b0);
        for (int b = 0; b < 4; b++) begin
            mem_dc_valid = 1'b1; mem_dc_rdata = beats[b];
            lsq_dc_flush = (b == flush_beat);
            @(negedge clk);
        end
        mem_dc_valid = 1'b0; lsq_dc_flush = 1'b0;
    endtask

    task automatic serve_write(input string tag, input logic [31:0] addr, input logic [3:0] mask,
                               input logic [31:0] wd);
        check({tag, "_wr_req"}, dc_mem_req, 1'b1);
        check({tag, "_wr_we"}, dc_mem_we, 1'b1);
        check({tag, "_wr_addr"}, dc_mem_addr, addr);
        check({tag, "_wr_mask"}, dc_mem_wmask, mask);
        check({tag, "_wr_data"}, dc_mem_wdata, wd);
        check({tag, "_no_resp"}, dcache_valid, 1'b0);
        lsq_dc_flush = 1'b1;
        @(negedge clk);
        lsq_dc_flush = 1'b0;
        check({tag, "_wr_held"}, dc_mem_req, 1'b1);
        mem_dc_ready = 1'b1;
        @(negedge clk);
        mem_dc_ready = 1'b0;
        check({tag, "_wr_done"}, dc_mem_req, 1'b0);
        check({tag, "_idle"}, dcache_ready, 1'b1);
    endtask

    task automatic expect_load(input string tag, input logic [3:0] id, input logic [31:0] data);
        check({tag, "_valid"}, dcache_valid, 1'b1);
        check({tag, "_error"}, dcache_error, 1'b0);
        check({tag, "_lsqid"}, dcache_lsqid, id);
        check({tag, "_rdata"}, dcache_rdata, data);
        check({tag, "_no_mem"}, dc_mem_req, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        lsq_dc_req = 1'b0; lsq_dc_flush = 1'b0; lsq_dc_op = '0; lsq_dc_addr = '0;
        lsq_dc_lsqid = '0; lsq_dc_wdata = '0;
        mem_dc_ready = 1'b0; mem_dc_valid = 1'b0; mem_dc_rdata = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", dcache_ready, 1'b0);
        check("rst_valid", dcache_valid, 1'b0);
        check("rst_error", dcache_error, 1'b0);
        check("rst_lsqid", dcache_lsqid, 4'd0);
        check("rst_rdata", dcache_rdata, 32'd0);
        check("rst_mem_req", dc_mem_req, 1'b0);
        check("rst_mem_we", dc_mem_we, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", dcache_ready, 1'b1);

        // Cold miss, refill, then hit in the same line
        issue(LW, 32'h100, 4'd3, '0, 1'b0);
        check("cold_no_resp", dcache_valid, 1'b0);
        serve_refill("cold", 32'h100, 32'hA, 32'hB, 32'hC, 32'hD, -1);
        check("cold_valid", dcache_valid, 1'b1);
        check("cold_error", dcache_error, 1'b0);
        check("cold_lsqid", dcache_lsqid, 4'd3);
        check("cold_rdata", dcache_rdata, 32'hA);
        @(negedge clk);
        check("cold_pulse", dcache_valid, 1'b0);
        issue(LW, 32'h104, 4'd5, '0, 1'b0);
        expect_load("hit104", 4'd5, 32'hB);

        // Sign/zero extension on store-updated words
        issue(SW, 32'h108, 4'd0, 32'h0000_80FF, 1'b0);
        serve_write("sw108a", 32'h108, 4'hF, 32'h0000_80FF);
        issue(LB, 32'h108, 4'd1, '0, 1'b0);
        expect_load("lb108", 4'd1, 32'hFFFF_FFFF);
        issue(LBU, 32'h108, 4'd2, '0, 1'b0);
        expect_load("lbu108", 4'd2, 32'h0000_00FF);
        issue(LH, 32'h108, 4'd3, '0, 1'b0);
        expect_load("lh108", 4'd3, 32'hFFFF_80FF);
        issue(SW, 32'h108, 4'd0, 32'h8000_0000, 1'b0);
        serve_write("sw108b", 32'h108, 4'hF, 32'h8000_0000);
        issue(LH, 32'h10A, 4'd4, '0, 1'b0);
        expect_load("lh10a", 4'd4, 32'hFFFF_8000);
        issue(LHU, 32'h10A, 4'd6, '0, 1'b0);
        expect_load("lhu10a", 4'd6, 32'h0000_8000);
        issue(LB, 32'h10B, 4'd8, '0, 1'b0);
        expect_load("lb10b", 4'd8, 32'hFFFF_FF80);

        // Byte and half stores on a resident line
        issue(SB, 32'h105, 4'd0, 32'h0000_005A, 1'b0);
        serve_write("sb105", 32'h104, 4'b0010, 32'h5A5A_5A5A);
        issue(LW, 32'h104, 4'd9, '0, 1'b0);
        expect_load("lw104_sb", 4'd9, 32'h0000_5A0B);
        issue(SH, 32'h106, 4'd0, 32'h0000_1234, 1'b0);
        serve_write("sh106", 32'h104, 4'b1100, 32'h1234_1234);
        issue(LW, 32'h104, 4'd10, '0, 1'b0);
        expect_load("lw104_sh", 4'd10, 32'h1234_5A0B);

        // Misalignment
        issue(LW, 32'h102, 4'd7, '0, 1'b0);
        check("mis_lw_valid", dcache_valid, 1'b1);
        check("mis_lw_error", dcache_error, 1'b1);
        check("mis_lw_lsqid", dcache_lsqid, 4'd7);
        check("mis_lw_rdata", dcache_rdata, 32'd0);
        check("mis_lw_no_mem", dc_mem_req, 1'b0);
        issue(LH, 32'h101, 4'd9, '0, 1'b0);
        check("mis_lh_error", dcache_error, 1'b1);
        check("mis_lh_lsqid", dcache_lsqid, 4'd9);
        issue(SW, 32'h102, 4'd0, 32'hFFFF_FFFF, 1'b0);
        check("mis_sw_no_resp", dcache_valid, 1'b0);
        check("mis_sw_no_mem", dc_mem_req, 1'b0);
        check("mis_sw_idle", dcache_ready, 1'b1);

        // Request presented together with flush is ignored
        issue(LW, 32'h104, 4'd11, '0, 1'b1);
        check("flushreq_no_resp", dcache_valid, 1'b0);
        check("flushreq_no_mem", dc_mem_req, 1'b0);

        // Flush during refill kills the response but still installs the line
        issue(LW, 32'h300, 4'd2, '0, 1'b0);
        serve_refill("flush", 32'h300, 32'h11, 32'h22, 32'h33, 32'h44, 1);
        check("flush_killed", dcache_valid, 1'b0);
        @(negedge clk);
        check("flush_killed2", dcache_valid, 1'b0);
        issue(LW, 32'h304, 4'd4, '0, 1'b0);
        expect_load("flush_hit", 4'd4, 32'h22);

        // Store miss: write-through without allocation
        issue(SW, 32'h700, 4'd0, 32'hCAFE_F00D, 1'b0);
        serve_write("swmiss", 32'h700, 4'hF, 32'hCAFE_F00D);
        issue(LW, 32'h700, 4'd12, '0, 1'b0);
        check("swmiss_load_misses", dcache_valid, 1'b0);
        serve_refill("ldmiss", 32'h700, 32'h71, 32'h72, 32'h73, 32'h74, -1);
        check("ldmiss_rdata", dcache_rdata, 32'h71);
        check("ldmiss_lsqid", dcache_lsqid, 4'd12);

        // Reset during refill beat 2
        issue(LW, 32'h400, 4'd1, '0, 1'b0);
        wait_mem("rstref");
        mem_dc_ready = 1'b1;
        @(negedge clk);
        mem_dc_ready = 1'b0;
        mem_dc_valid = 1'b1; mem_dc_rdata = 32'h41;
        @(negedge clk);
        mem_dc_rdata = 32'h42;
        @(negedge clk);
        mem_dc_rdata = 32'h43; rst = 1'b1;
        @(negedge clk);
        mem_dc_valid = 1'b0;
        check("midrst_ready", dcache_ready, 1'b0);
        check("midrst_valid", dcache_valid, 1'b0);
        check("midrst_mem_req", dc_mem_req, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idle", dcache_ready, 1'b1);
        check("midrst_no_resp", dcache_valid, 1'b0);
        issue(LW, 32'h304, 4'd5, '0, 1'b0);
        check("postrst_miss_valid", dcache_valid, 1'b0);
        serve_refill("postrst", 32'h300, 32'h1, 32'h2, 32'h3, 32'h4, -1);
        check("postrst_rdata", dcache_rdata, 32'h2);
        check("postrst_lsqid", dcache_lsqid, 4'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
